// File: rtl/bus_pkg.sv
// Shared definitions for the bus arbiter: FSM state encoding and the
// helper that sizes the last-granted pointer.
package bus_pkg;

    // Arbiter ownership states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_OWNED  = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    // Bits needed to index one of n channels (never less than one bit)
    function automatic int ptr_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/bus_rr_pick.sv
// Combinational round-robin picker: returns the first requesting,
// non-excluded channel strictly above the pointer, wrapping to 0.
module bus_rr_pick
    import bus_pkg::*;
#(
    parameter int COUNT = 4,
    parameter int PW    = ptr_w(COUNT)
) (
    input  logic [COUNT-1:0] req_i,
    input  logic [PW-1:0]    ptr_i,
    input  logic [COUNT-1:0] excl_i,
    output logic [COUNT-1:0] win_o,
    output logic [PW-1:0]    win_idx_o,
    output logic             any_o
);

    logic [COUNT-1:0] masked;

    assign masked = req_i & ~excl_i;

    // Scan channels starting one above the pointer; first hit wins
    always_comb begin
        win_o     = '0;
        win_idx_o = '0;
        any_o     = 1'b0;
        for (int off = 1; off <= COUNT; off++) begin
            int idx;
            idx = (int'(ptr_i) + off) % COUNT;
            if (!any_o && masked[idx]) begin
                any_o      = 1'b1;
                win_o[idx] = 1'b1;
                win_idx_o  = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with per-owner lock and registered data mux.
// Optional feature: define BUS_TIMEOUT_EN to bound consecutive locked
// cycles at HOLD_MAX and force the owner off with a one-cycle timeout pulse.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int COUNT    = 4,
    parameter int HOLD_MAX = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [WIDTH*COUNT-1:0] in,
    input  logic [COUNT-1:0]       req,
    input  logic [COUNT-1:0]       lock,
    output logic [COUNT-1:0]       grant,
    output logic [WIDTH-1:0]       out,
    output logic                   out_valid,
    output logic                   timeout
);

    localparam int PW = ptr_w(COUNT);

    state_t           state_q, state_d;
    logic [COUNT-1:0] grant_q, grant_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic [PW-1:0]    ptr_q, ptr_d;

    logic [WIDTH-1:0] chan [COUNT];
    logic             keep_lock;
    logic             force_rel;
    logic [COUNT-1:0] excl;
    logic [COUNT-1:0] pick_win;
    logic [PW-1:0]    pick_idx;
    logic             pick_any;

    // Slice the flat input bus into per-channel words
    for (genvar gi = 0; gi < COUNT; gi++) begin : g_chan
        assign chan[gi] = in[gi*WIDTH +: WIDTH];
    end

    // In LOCKED the pointer is the owner; it keeps the bus while it asks to
    assign keep_lock = (state_q == ST_LOCKED) && req[ptr_q] && lock[ptr_q];

`ifdef BUS_TIMEOUT_EN
    localparam int HW = $clog2(HOLD_MAX + 1);

    logic [HW-1:0] hold_q, hold_d;
    logic          timeout_q;

    assign force_rel = keep_lock && (int'(hold_q) >= HOLD_MAX);

    // Count locked cycles of the current owner; restart on any new grant
    always_comb begin
        hold_d = '0;
        if (keep_lock && !force_rel) begin
            hold_d = hold_q + 1'b1;
        end else if (pick_any && lock[pick_idx]) begin
            hold_d = HW'(1);
        end
    end

    // Hold counter and timeout pulse registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_q    <= '0;
            timeout_q <= 1'b0;
        end else begin
            hold_q    <= hold_d;
            timeout_q <= force_rel;
        end
    end

    assign timeout = timeout_q;
`else
    logic unused_hold_cfg;

    assign unused_hold_cfg = (HOLD_MAX > 0);
    assign force_rel       = 1'b0;
    assign timeout         = 1'b0;
`endif

    // A forced release keeps the expiring owner out of this edge's pick
    assign excl = force_rel ? grant_q : '0;

    bus_rr_pick #(
        .COUNT (COUNT),
        .PW    (PW)
    ) u_pick (
        .req_i     (req),
        .ptr_i     (ptr_q),
        .excl_i    (excl),
        .win_o     (pick_win),
        .win_idx_o (pick_idx),
        .any_o     (pick_any)
    );

    // Next-state: stay locked, re-arbitrate, or fall back to idle
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        out_d   = out_q;
        ptr_d   = ptr_q;
        if (keep_lock && !force_rel) begin
            out_d = chan[ptr_q];
        end else if (pick_any) begin
            grant_d = pick_win;
            ptr_d   = pick_idx;
            out_d   = chan[pick_idx];
            state_d = lock[pick_idx] ? ST_LOCKED : ST_OWNED;
        end else begin
            grant_d = '0;
            state_d = ST_IDLE;
        end
    end

    // Ownership, data and pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            out_q   <= '0;
            ptr_q   <= PW'(COUNT - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            out_q   <= out_d;
            ptr_q   <= ptr_d;
        end
    end

    assign grant     = grant_q;
    assign out       = out_q;
    assign out_valid = |grant_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed testbench for bus_arbiter (WIDTH=8, COUNT=4, HOLD_MAX=4).
// Build with BUS_TIMEOUT_EN defined to exercise the forced-release path.
module tb_bus_arbiter;

    localparam int WIDTH = 8;
    localparam int COUNT = 4;

    logic                   clk;
    logic                   rst_n;
    logic [WIDTH*COUNT-1:0] in;
    logic [COUNT-1:0]       req;
    logic [COUNT-1:0]       lock;
    logic [COUNT-1:0]       grant;
    logic [WIDTH-1:0]       out;
    logic                   out_valid;
    logic                   timeout;

    int n_checks = 0;
    int n_fail   = 0;

`ifdef BUS_TIMEOUT_EN
    localparam int LOCK_LEN = 4;
`else
    localparam int LOCK_LEN = 5;
`endif

    bus_arbiter #(
        .WIDTH    (WIDTH),
        .COUNT    (COUNT),
        .HOLD_MAX (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in),
        .req       (req),
        .lock      (lock),
        .grant     (grant),
        .out       (out),
        .out_valid (out_valid),
        .timeout   (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        lock  = '0;
        step();
        rst_n = 1'b1;
    endtask

    initial begin
        logic [3:0] exp_g [5];
        logic [7:0] exp_o [5];
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_o = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h01};

        rst_n = 1'b0;
        req   = '0;
        lock  = '0;
        in    = 32'h04030201;
        #1;
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_out", 32'(out), 32'h0);
        check("rst_valid", 32'(out_valid), 32'h0);
        check("rst_timeout", 32'(timeout), 32'h0);
        step();
        rst_n = 1'b1;

        // Single request, then release
        req = 4'b0001;
        step();
        check("single_grant", 32'(grant), 32'h1);
        check("single_out", 32'(out), 32'h01);
        check("single_valid", 32'(out_valid), 32'h1);
        req = 4'b0000;
        step();
        check("idle_grant", 32'(grant), 32'h0);
        check("idle_valid", 32'(out_valid), 32'h0);
        check("idle_out_hold", 32'(out), 32'h01);

        // Round-robin rotation from a fresh pointer
        do_reset();
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("rr_grant%0d", i), 32'(grant), 32'(exp_g[i]));
            check($sformatf("rr_out%0d", i), 32'(out), 32'(exp_o[i]));
        end

        // Lock held by ch1, data change followed, then drop lock
        req  = 4'b0110;
        lock = 4'b0010;
        for (int i = 0; i < LOCK_LEN; i++) begin
            step();
            check($sformatf("lock_grant%0d", i), 32'(grant), 32'h2);
            check($sformatf("lock_out%0d", i), 32'(out), (i >= 2) ? 32'hA5 : 32'h02);
            if (i == 1) in = 32'h0403A501;
        end
        in   = 32'h04030201;
        lock = 4'b0000;
        step();
        check("unlock_grant", 32'(grant), 32'h4);
        check("unlock_out", 32'(out), 32'h03);
        check("unlock_valid", 32'(out_valid), 32'h1);

        // Asynchronous reset in the middle of a lock
        req  = 4'b0010;
        lock = 4'b0010;
        step();
        step();
        check("prelock_grant", 32'(grant), 32'h2);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_grant", 32'(grant), 32'h0);
        check("async_out", 32'(out), 32'h0);
        check("async_valid", 32'(out_valid), 32'h0);
        step();
        check("inrst_grant", 32'(grant), 32'h0);
        rst_n = 1'b1;
        req   = 4'b1000;
        lock  = 4'b0000;
        step();
        check("postrst_grant", 32'(grant), 32'h8);
        check("postrst_out", 32'(out), 32'h04);

        // Long lock: forced release only with the timeout feature
        do_reset();
        req  = 4'b0011;
        lock = 4'b0001;
        for (int i = 0; i < 4; i++) begin
            step();
            check($sformatf("hold_grant%0d", i), 32'(grant), 32'h1);
            check($sformatf("hold_timeout%0d", i), 32'(timeout), 32'h0);
        end
        step();
`ifdef BUS_TIMEOUT_EN
        check("force_grant", 32'(grant), 32'h2);
        check("force_timeout", 32'(timeout), 32'h1);
        check("force_out", 32'(out), 32'h02);
        step();
        check("after_force_grant", 32'(grant), 32'h1);
        check("after_force_timeout", 32'(timeout), 32'h0);
`else
        check("nolimit_grant", 32'(grant), 32'h1);
        check("nolimit_timeout", 32'(timeout), 32'h0);
        step();
        check("nolimit_grant2", 32'(grant), 32'h1);
        check("nolimit_timeout2", 32'(timeout), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
